// File: rtl/r88_memctl.sv
`timescale 1ns/1ps
// r88_memctl: Rocket88 memory controller. Turns decoder read/write request edges into
// strobed external bus cycles (SETUP, ACCESS, DONE) with fixed wait states, an external
// ready handshake and an ACCESS watchdog. Read data is returned on intD during DONE.
module r88_memctl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        readMem,
  input  logic        writeMem,
  input  logic        mc_use_regAddr,
  input  logic        mc_write_low,
  input  logic        mc_write_high,
  input  logic [15:0] regAddr,
  inout  logic [7:0]  intD,
  output logic [15:0] extAddr,
  inout  logic [7:0]  extData,
  output logic        extRd_n,
  output logic        extWr_n,
  input  logic        extReady,
  output logic        memBusy,
  output logic        memDone,
  output logic        memErr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [7:0] WaitLim    = 8'(WAIT_STATES);
  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  state_e      state;
  logic        prevRead;
  logic        prevWrite;
  logic [15:0] addrLatch;
  logic [15:0] addrReg;
  logic [7:0]  wrBuf;
  logic [7:0]  rdBuf;
  logic        isWrite;
  logic [7:0]  waitCnt;
  logic        extDriveEn;
  logic        intDriveEn;

  logic        riseRd;
  logic        riseWr;
  logic [15:0] startAddr;
  logic        accessExit;
  logic [8:0]  cntNext;
  logic        timeoutHit;

  assign riseRd     = readMem & ~prevRead;
  assign riseWr     = writeMem & ~prevWrite;
  assign startAddr  = mc_use_regAddr ? regAddr : addrLatch;
  assign accessExit = (waitCnt >= WaitLim) && extReady;
  // Watchdog fires when the cycle now ending would bring the count up to TIMEOUT.
  assign cntNext    = {1'b0, waitCnt} + 9'd1;
  assign timeoutHit = cntNext >= TimeoutLim;

  // addrReg only changes on a start, so extAddr holds its value through IDLE.
  assign extAddr = addrReg;
  assign intD    = intDriveEn ? rdBuf : 8'hzz;
  assign extData = extDriveEn ? wrBuf : 8'hzz;

  // Address latch: loads from intD in any state, independent of the access in flight.
  always_ff @(posedge sysClock or posedge resetReq) begin
    if (resetReq) begin
      addrLatch <= 16'h0000;
    end else begin
      if (mc_write_low) begin
        addrLatch[7:0] <= intD;
      end
      if (mc_write_high) begin
        addrLatch[15:8] <= intD;
      end
    end
  end

  // Access sequencer with registered strobes, bus enables and status pulses.
  always_ff @(posedge sysClock or posedge resetReq) begin
    if (resetReq) begin
      state      <= StIdle;
      prevRead   <= 1'b0;
      prevWrite  <= 1'b0;
      addrReg    <= 16'h0000;
      wrBuf      <= 8'h00;
      rdBuf      <= 8'h00;
      isWrite    <= 1'b0;
      waitCnt    <= 8'h00;
      extRd_n    <= 1'b1;
      extWr_n    <= 1'b1;
      memBusy    <= 1'b0;
      memDone    <= 1'b0;
      memErr     <= 1'b0;
      extDriveEn <= 1'b0;
      intDriveEn <= 1'b0;
    end else begin
      // Edge history tracks the inputs in every state so held requests never retrigger.
      prevRead  <= readMem;
      prevWrite <= writeMem;
      memDone   <= 1'b0;
      memErr    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (riseRd && riseWr) begin
            memErr <= 1'b1;
          end else if (riseRd || riseWr) begin
            addrReg    <= startAddr;
            isWrite    <= riseWr;
            extDriveEn <= riseWr;
            memBusy    <= 1'b1;
            if (riseWr) begin
              wrBuf <= intD;
            end
            state <= StSetup;
          end
        end
        StSetup: begin
          extRd_n <= isWrite;
          extWr_n <= ~isWrite;
          waitCnt <= 8'h00;
          state   <= StAccess;
        end
        StAccess: begin
          if (accessExit || timeoutHit) begin
            extRd_n    <= 1'b1;
            extWr_n    <= 1'b1;
            memBusy    <= 1'b0;
            extDriveEn <= 1'b0;
            memDone    <= 1'b1;
            intDriveEn <= ~isWrite;
            state      <= StDone;
            // A ready completion beats the watchdog when both land on the same cycle.
            if (accessExit) begin
              if (!isWrite) begin
                rdBuf <= extData;
              end
            end else begin
              rdBuf  <= 8'hFF;
              memErr <= 1'b1;
            end
          end else if (waitCnt != 8'hFF) begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        StDone: begin
          intDriveEn <= 1'b0;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
